// File: rtl/pulse_pkg.sv
// Shared types and helpers for the retriggerable pulse stretcher.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        GAP    = 2'b10
    } state_e;

    localparam int DEF_CW      = 8;
    localparam int DEF_MIN_LOW = 2;

    // Requested length to terminal count: max(len,1)-1.
    function automatic logic [31:0] len_to_cnt(input logic [31:0] l);
        return (l == 32'd0) ? 32'd0 : l - 32'd1;
    endfunction

    function automatic int gap_width(input int min_low);
        return (min_low < 2) ? 1 : $clog2(min_low + 1);
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable saturating down-counter with a zero flag.
module down_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Retriggerable one-shot: stretches a trigger pulse into a registered
// level of programmable width followed by a minimum low gap.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int CW      = DEF_CW,
    parameter int MIN_LOW = DEF_MIN_LOW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    input  logic [CW-1:0] len,
    input  logic          retrig_en,
    output logic          z,
    output logic          busy,
    output logic          done,
    output logic          drop
);

    localparam int GW = gap_width(MIN_LOW);
    localparam logic [GW-1:0] GAP_INIT =
        (MIN_LOW > 0) ? GW'(MIN_LOW - 1) : '0;

    state_e state_q;
    state_e state_d;

    logic z_q;
    logic busy_q;
    logic done_q;
    logic drop_q;

    logic start;
    logic reload;
    logic ignored;
    logic act_end;

    logic          len_zero;
    logic          len_load;
    logic          len_dec;
    logic [CW-1:0] len_cnt;
    logic          gap_zero;
    logic          gap_load;
    logic          gap_dec;

    assign len_cnt = CW'(len_to_cnt(32'(len)));

    always_comb begin
        start   = 1'b0;
        reload  = 1'b0;
        ignored = 1'b0;
        act_end = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    start   = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // A reload beats the terminal-count exit on the same edge.
                if (trig && retrig_en) begin
                    reload = 1'b1;
                end else begin
                    ignored = trig;
                    if (len_zero) begin
                        act_end = 1'b1;
                        state_d = (MIN_LOW == 0) ? IDLE : GAP;
                    end
                end
            end
            GAP: begin
                ignored = trig;
                if (gap_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign len_load = start | reload;
    assign len_dec  = (state_q == ACTIVE) & ~reload & ~len_zero;
    assign gap_load = act_end & (MIN_LOW > 0);
    assign gap_dec  = (state_q == GAP);

    down_counter #(
        .W(CW)
    ) u_len_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (len_load),
        .val_i  (len_cnt),
        .dec_i  (len_dec),
        .zero_o (len_zero)
    );

    down_counter #(
        .W(GW)
    ) u_gap_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (gap_load),
        .val_i  (GAP_INIT),
        .dec_i  (gap_dec),
        .zero_o (gap_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= (state_d == ACTIVE);
            busy_q  <= (state_d != IDLE);
            done_q  <= act_end;
            drop_q  <= ignored;
        end
    end

    assign z    = z_q;
    assign busy = busy_q;
    assign done = done_q;
    assign drop = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher (CW=8, MIN_LOW=2).
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       trig;
    logic [7:0] len;
    logic       retrig_en;
    logic       z;
    logic       busy;
    logic       done;
    logic       drop;

    pulse_stretcher #(
        .CW      (8),
        .MIN_LOW (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .len       (len),
        .retrig_en (retrig_en),
        .z         (z),
        .busy      (busy),
        .done      (done),
        .drop      (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       trig;
        logic [7:0] len;
        logic       ren;
        logic [3:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [3:0] sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         vec_id  = 0;

    logic [3:0] outs;
    assign outs = {z, busy, done, drop};

    task automatic v(input logic t, input logic [7:0] l,
                     input logic r, input logic [3:0] e);
        vec_t x;
        x.trig = t;
        x.len  = l;
        x.ren  = r;
        x.exp  = e;
        tbl.push_back(x);
    endtask

    task automatic check4(input string nm, input logic [3:0] got,
                          input logic [3:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: z/busy/done/drop got %b want %b",
                     nm, got, want);
        end
    endtask

    task automatic check_int(input string nm, input int got,
                             input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Expected outputs are queued when a vector is driven and
    // popped one edge later when the registered outputs appear.
    task automatic run_tbl();
        logic [3:0] e;
        for (int i = 0; i < tbl.size(); i++) begin
            trig      = tbl[i].trig;
            len       = tbl[i].len;
            retrig_en = tbl[i].ren;
            sb.push_back(tbl[i].exp);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check4($sformatf("vec%0d", vec_id), outs, e);
            vec_id++;
        end
        tbl.delete();
        trig = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) v(1'b0, 8'd0, 1'b0, 4'b0000);
    endtask

    initial begin
        int hi;
        rst       = 1'b0;
        trig      = 1'b0;
        len       = 8'd0;
        retrig_en = 1'b0;

        for (int i = 0; i < 3; i++) begin
            trig = ~trig;
            len  = 8'd5;
            @(posedge clk);
            #1;
            check4("rst_hold", outs, 4'b0000);
        end
        trig = 1'b0;
        rst  = 1'b1;

        idle(10);

        // basic len=5
        v(1'b1, 8'd5, 1'b0, 4'b1100);
        for (int i = 0; i < 4; i++) v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b0110);
        v(1'b0, 8'd0, 1'b0, 4'b0100);
        v(1'b0, 8'd0, 1'b0, 4'b0000);
        idle(2);

        // len=0 and len=1 both give one high cycle
        for (int l = 0; l < 2; l++) begin
            v(1'b1, 8'(l), 1'b0, 4'b1100);
            v(1'b0, 8'd0, 1'b0, 4'b0110);
            v(1'b0, 8'd0, 1'b0, 4'b0100);
            v(1'b0, 8'd0, 1'b0, 4'b0000);
        end

        // retrigger accepted
        v(1'b1, 8'd4, 1'b1, 4'b1100);
        v(1'b0, 8'd0, 1'b1, 4'b1100);
        v(1'b1, 8'd4, 1'b1, 4'b1100);
        for (int i = 0; i < 3; i++) v(1'b0, 8'd0, 1'b1, 4'b1100);
        v(1'b0, 8'd0, 1'b1, 4'b0110);
        v(1'b0, 8'd0, 1'b1, 4'b0100);
        v(1'b0, 8'd0, 1'b1, 4'b0000);

        // retrigger refused
        v(1'b1, 8'd4, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b1, 8'd4, 1'b0, 4'b1101);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b0110);
        v(1'b0, 8'd0, 1'b0, 4'b0100);
        v(1'b0, 8'd0, 1'b0, 4'b0000);

        // trig in GAP dropped, trig right after accepted
        v(1'b1, 8'd3, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b0110);
        v(1'b0, 8'd0, 1'b0, 4'b0100);
        v(1'b1, 8'd3, 1'b0, 4'b0001);
        v(1'b1, 8'd3, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b0110);
        v(1'b0, 8'd0, 1'b0, 4'b0100);
        v(1'b0, 8'd0, 1'b0, 4'b0000);

        // trig in GAP with retrig_en still dropped
        v(1'b1, 8'd1, 1'b1, 4'b1100);
        v(1'b0, 8'd0, 1'b1, 4'b0110);
        v(1'b1, 8'd1, 1'b1, 4'b0101);
        v(1'b0, 8'd0, 1'b0, 4'b0000);

        // reload on the terminal-count cycle
        v(1'b1, 8'd2, 1'b1, 4'b1100);
        v(1'b0, 8'd0, 1'b1, 4'b1100);
        v(1'b1, 8'd1, 1'b1, 4'b1100);
        v(1'b0, 8'd0, 1'b1, 4'b0110);
        v(1'b0, 8'd0, 1'b1, 4'b0100);
        v(1'b0, 8'd0, 1'b1, 4'b0000);
        run_tbl();

        // len=255: full-width count, no wrap
        trig = 1'b1;
        len  = 8'd255;
        @(posedge clk);
        #1;
        trig = 1'b0;
        len  = 8'd0;
        hi   = 0;
        while (z && hi < 300) begin
            hi++;
            @(posedge clk);
            #1;
        end
        check_int("len255_high", hi, 255);
        check4("len255_done", outs, 4'b0110);
        repeat (2) @(posedge clk);
        #1;
        check4("len255_idle", outs, 4'b0000);

        // asynchronous reset mid-pulse
        trig = 1'b1;
        len  = 8'd10;
        @(posedge clk);
        #1;
        trig = 1'b0;
        check4("pre_rst", outs, 4'b1100);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check4("async_rst", outs, 4'b0000);
        @(posedge clk);
        #1;
        check4("rst_no_done", outs, 4'b0000);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check4("post_rst", outs, 4'b0000);
        v(1'b1, 8'd2, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b1100);
        v(1'b0, 8'd0, 1'b0, 4'b0110);
        v(1'b0, 8'd0, 1'b0, 4'b0100);
        v(1'b0, 8'd0, 1'b0, 4'b0000);
        run_tbl();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
